// File: rtl/bmem_arbiter_pkg.sv
// Shared types and constants for the burst-memory arbiter.
package bmem_arbiter_pkg;

  localparam int LINE_BITS  = 256;
  localparam int BEAT_BITS  = 64;
  localparam int BEATS      = LINE_BITS / BEAT_BITS;
  localparam int BEAT_CNT_W = 2;
  localparam int LINE_OFS_W = 5;

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_DATA = 3'd3,
    ST_WR_ACK  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // Next beat slot, wrapping from the last slot back to 0.
  function automatic logic [BEAT_CNT_W-1:0] beat_inc(input logic [BEAT_CNT_W-1:0] k);
    return k + 1'b1;
  endfunction

endpackage

// File: rtl/bmem_arbiter_line_deserializer.sv
// Beat counter plus line register: assembles read beats into a line and
// slices a latched writeback line back into beats.
module line_deserializer
  import bmem_arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_BITS,
  parameter int BEAT_W = BEAT_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic [LINE_W-1:0]     load_line,
  input  logic                  clr_en,
  input  logic                  cap_en,
  input  logic [BEAT_W-1:0]     cap_beat,
  input  logic                  adv_en,
  input  logic [BEAT_CNT_W-1:0] slice_idx,
  output logic [BEAT_W-1:0]     slice_beat,
  output logic [LINE_W-1:0]     line,
  output logic [BEAT_CNT_W-1:0] cnt,
  output logic                  last_beat
);

  localparam int NB = LINE_W / BEAT_W;

  logic [NB-1:0][BEAT_W-1:0] line_q, line_d;
  logic [BEAT_CNT_W-1:0]     cnt_q, cnt_d;

  // Load wins over capture/advance; a capture writes the slot the counter points at.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (load_en) begin
      line_d = load_line;
      cnt_d  = '0;
    end else if (clr_en) begin
      cnt_d = '0;
    end else if (cap_en) begin
      line_d[cnt_q] = cap_beat;
      cnt_d         = beat_inc(cnt_q);
    end else if (adv_en) begin
      cnt_d = beat_inc(cnt_q);
    end
  end

  // Line and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign slice_beat = line_q[slice_idx];
  assign line       = line_q;
  assign cnt        = cnt_q;
  assign last_beat  = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single burst memory.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | sample requests, grant one, latch address/id/wdata
// ST_RD_CMD  | bmem_read high for this single cycle
// ST_RD_DATA | collect four read beats on bmem_resp (gaps allowed)
// ST_WR_DATA | four back-to-back write beats
// ST_WR_ACK  | wait for the write acknowledge
// ST_DONE    | one-cycle completion pulse to the granted side
module bmem_arbiter
  import bmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = LINE_BITS,
  parameter int BEAT_W = BEAT_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_address,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_resp,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W - LINE_OFS_W){1'b1}}, {LINE_OFS_W{1'b0}}};

  state_e              state_q, state_d;
  // Owner of the current transfer; it is also the "last granted" side for
  // round-robin, since both change only at grant time.
  gnt_e                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [BEAT_W-1:0]   wdata_q, wdata_d;
  logic                i_resp_q, i_resp_d;
  logic                d_resp_q, d_resp_d;
  logic                busy_q, busy_d;

  logic                  ds_load, ds_clr, ds_cap, ds_adv;
  logic [BEAT_CNT_W-1:0] ds_idx, ds_cnt;
  logic [BEAT_W-1:0]     ds_slice;
  logic [LINE_W-1:0]     ds_line;
  logic                  ds_last;

  logic                  d_req, pick_d;
  logic [ADDR_W-1:0]     req_addr;

  // On a tie the side that did not win last time is granted.
  assign d_req    = d_read | d_write;
  assign pick_d   = d_req & (~i_read | (gnt_q == GNT_I));
  assign req_addr = (pick_d ? d_addr : i_addr) & LINE_MASK;

  // Slice for the beat that goes out on the next cycle.
  assign ds_idx   = beat_inc(ds_cnt);

  line_deserializer #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W)
  ) u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (ds_load),
    .load_line  (d_wdata),
    .clr_en     (ds_clr),
    .cap_en     (ds_cap),
    .cap_beat   (bmem_rdata),
    .adv_en     (ds_adv),
    .slice_idx  (ds_idx),
    .slice_beat (ds_slice),
    .line       (ds_line),
    .cnt        (ds_cnt),
    .last_beat  (ds_last)
  );

  // Next-state, grant and registered-output decode.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    wdata_d  = '0;
    i_resp_d = 1'b0;
    d_resp_d = 1'b0;
    ds_load  = 1'b0;
    ds_clr   = 1'b0;
    ds_cap   = 1'b0;
    ds_adv   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_read || d_req) begin
          gnt_d  = pick_d ? GNT_D : GNT_I;
          addr_d = req_addr;
          // Writeback takes priority over fill when both are raised.
          if (pick_d && d_write) begin
            state_d = ST_WR_DATA;
            wr_d    = 1'b1;
            wdata_d = d_wdata[BEAT_W-1:0];
            ds_load = 1'b1;
          end else begin
            state_d = ST_RD_CMD;
            rd_d    = 1'b1;
            ds_clr  = 1'b1;
          end
        end
      end

      ST_RD_CMD: begin
        state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        if (bmem_resp) begin
          ds_cap = 1'b1;
          if (ds_last) begin
            state_d  = ST_DONE;
            i_resp_d = (gnt_q == GNT_I);
            d_resp_d = (gnt_q == GNT_D);
          end
        end
      end

      ST_WR_DATA: begin
        ds_adv = 1'b1;
        if (ds_last) begin
          state_d = ST_WR_ACK;
        end else begin
          wr_d    = 1'b1;
          wdata_d = ds_slice;
        end
      end

      ST_WR_ACK: begin
        if (bmem_resp) begin
          state_d  = ST_DONE;
          i_resp_d = (gnt_q == GNT_I);
          d_resp_d = (gnt_q == GNT_D);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= GNT_I;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      i_resp_q <= i_resp_d;
      d_resp_q <= d_resp_d;
      busy_q   <= busy_d;
    end
  end

  assign bmem_address = addr_q;
  assign bmem_read    = rd_q;
  assign bmem_write   = wr_q;
  assign bmem_wdata   = wdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign busy         = busy_q;
  // Both sides see the shared line register; only the pulsed side's copy matters.
  assign i_rdata      = ds_line;
  assign d_rdata      = ds_line;

endmodule
